// File: rtl/parity_frame_ctrl.sv
// Frames a serial bit stream into DATA_BITS data bits plus one parity bit, checks parity
// and reports the captured word, an error flag and a saturating error count.
module parity_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 x,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 busy,
  output logic                 odd_now,
  output logic                 done,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 par_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_inc;

  assign w_accept = x_valid & x_ready;
  assign busy     = (r_state != S_IDLE);
  assign odd_now  = r_par & busy;
  // Aborting during DONE suppresses the pulse together with the result update.
  assign w_commit = (r_state == S_DONE) & ~abort;
  assign done     = w_commit;
  assign w_inc    = w_commit & r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    x_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_DATA;
      end
      S_DATA: begin
        x_ready = 1'b1;
        if (abort)                               w_next = S_IDLE;
        else if (w_accept && r_cnt == LAST_BIT)  w_next = S_PARITY;
      end
      S_PARITY: begin
        x_ready = 1'b1;
        if (abort)         w_next = S_IDLE;
        else if (w_accept) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_accept && !abort) begin
            r_shift <= {x, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ x;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_accept && !abort) r_err <= (x != (r_par ^ 1'(PARITY_ODD)));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data <= '0;
      par_err    <= 1'b0;
    end else if (w_commit) begin
      frame_data <= r_shift;
      par_err    <= r_err;
    end
  end

  // Clear wins over a stale count but a same-edge error still counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= w_inc ? CNT_W'(1) : '0;
    end else if (w_inc && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
- Sequencer for the serial parity datapath. It frames a serial bit stream into DATA_BITS data bits followed by one parity bit.
- Tracks running parity, checks the received parity bit and reports the captured word, an error flag and a saturating error count.
- Sits between a serial bit source using a valid/ready handshake and the downstream consumer of received words.

Parameters:
- DATA_BITS, 8: data bits per frame (legal range 2..16).
- PARITY_ODD, 0: 0 = even-parity scheme (total ones including the parity bit is even); 1 = odd-parity scheme.
- CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a frame; sampled only in IDLE.
- abort  in  1  synchronous abandon of the current frame.
- x  in  1  serial data/parity bit.
- x_valid  in  1  x is valid this cycle.
- x_ready  out  1  controller accepts a bit this cycle.
- busy  out  1  frame in progress (state is not IDLE).
- odd_now  out  1  live running parity of the data bits accepted so far in this frame (1 = odd count of ones).
- done  out  1  one-cycle pulse: frame complete.
- frame_data  out  DATA_BITS  last completed data word, LSB received first.
- par_err  out  1  parity result of the last completed frame.
- err_clr  in  1  clear the error counter.
- err_cnt  out  CNT_W  saturating count of frames with a parity error.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; bit counter, shift register and running parity all 0. Outputs: x_ready=0, busy=0, odd_now=0, done=0, frame_data=0, par_err=0, err_cnt=0.
- Handshake: a bit is accepted on a clock edge where x_valid=1 and x_ready=1. x_ready=1 only in DATA and PARITY. x_valid=0 holds all state (gaps of any length are legal).
- IDLE:
  - start=1 → DATA; counter, shift register and running parity cleared on the same edge.
  - start has no effect in any other state.
- DATA, on each accepted bit:
  - shift_reg <= {x, shift_reg[DATA_BITS-1:1]} (first bit lands in bit 0 after DATA_BITS shifts).
  - running parity ^= x; counter++.
  - The accept with counter==DATA_BITS-1 → PARITY.
- PARITY, on the accepted bit:
  - expected = running_parity ^ PARITY_ODD; err = (x != expected).
  - → DONE.
- DONE (exactly one cycle):
  - done=1; frame_data <= shift_reg; par_err <= err; x_ready=0.
  - err_cnt increments if err, saturating at 2^CNT_W-1.
  - → IDLE unconditionally. start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Latency: done is high the cycle after the parity bit is accepted. Minimum frame length is DATA_BITS+2 cycles from start accept to done, plus the return to IDLE.
- frame_data and par_err hold their values until the next DONE.
- abort=1 in DATA/PARITY/DONE:
  - → IDLE on that edge; no done pulse; frame_data, par_err and err_cnt unchanged.
  - abort has priority over a bit accepted the same cycle. abort in IDLE has no effect.
- err_clr:
  - err_cnt <= 0 on that edge.
  - If an error increment coincides with err_clr, err_cnt <= 1 (clear, then count).
- odd_now is 0 in IDLE and reflects the accepted data bits only; it does not include the parity bit.
- Reset asserted mid-frame discards the frame immediately; no done pulse.

Test Plan:
- DATA_BITS=8, PARITY_ODD=0; start; send 1,0,1,0,0,1,0,1 then parity 0 → done pulse exactly 1 cycle after the parity accept; frame_data=0xA5, par_err=0, err_cnt=0.
- Same frame with parity bit 1 → par_err=1, err_cnt=1. Then assert err_clr in the same cycle as the next error's DONE → err_cnt=1.
- PARITY_ODD=1; data 0x01 (send 1 then seven 0s) with parity 0 → par_err=0. Repeat with parity 1 → par_err=1.
- Insert random x_valid=0 gaps of 0–5 cycles between bits of 0x3C/parity 0 → same result as gap-free. odd_now toggles only on accepted 1s. x_ready stays 0 in IDLE and DONE.
- Abort after 4 bits → busy=0 next cycle, no done, frame_data keeps its prior value. Async reset after 5 bits → all outputs 0 immediately, before any clock edge.
- Force 255 error frames with CNT_W=8, then one more error frame → err_cnt stays 255. Start held high through DONE → exactly one new frame begins, and only after IDLE is re-entered.
